mux_n_1_serializer: RTL and testbench
=====================================

# mux_n_1_serializer

Parametrised time-multiplexing serializer for the matrix block-multiplier datapath: captures CHANNELS parallel WIDTH-bit results in one handshake, then emits them one per cycle on a single output bus with channel index and last-word flag. It replaces free-running fixed 4:1 selection with a valid/ready-controlled sequence that supports downstream stalls, variable word count and bubble-free back-to-back loads.

## Interface
- WIDTH, 16: bits per channel word.
- CHANNELS, 4: number of input channels; legal range 2..64.
- IDX_W (localparam), $clog2(CHANNELS): channel index width.

- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_data  in  WIDTH*CHANNELS  channel k at bits [k*WIDTH +: WIDTH].
- in_count  in  IDX_W+1  words to emit from this load, channels 0..in_count-1.
- in_valid  in  1  in_data/in_count are valid.
- in_ready  out  1  block accepts a load this cycle.
- out_data  out  WIDTH  current word.
- out_sel  out  IDX_W  channel index of out_data.
- out_valid  out  1  out_data/out_sel/out_last are valid.
- out_last  out  1  current word is the final one of its load.
- out_ready  in  1  downstream accepts the current word.
- busy  out  1  a load is being emitted (state SEND).

## Operation
- State register: IDLE, SEND. Registers: buffer of CHANNELS words, count_q (IDX_W+1), sel_q (IDX_W).
- Load handshake: in_valid && in_ready at a rising edge captures all of in_data into buffer, effective count into count_q, sets sel_q=0, next state SEND.
- Effective count: in_count when 1..CHANNELS; in_count==0 or >CHANNELS is treated as CHANNELS.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This is the only combinational input-to-output path; out_data/out_sel/out_valid/out_last/busy depend on registers only.
- SEND: out_valid=1, out_sel=sel_q, out_data=buffer[sel_q], out_last=(sel_q==count_q-1), busy=1.
- Word handshake (out_valid && out_ready): if not last, sel_q increments; if last and a load handshake occurs in the same cycle, the new load is captured, sel_q=0, state stays SEND; if last and no load, state goes IDLE.
- Stall: while out_valid && !out_ready, all outputs and registers hold; in_ready=0.
- IDLE: out_valid=0, out_last=0, busy=0; out_sel and out_data hold last driven values (0 after reset).
- sel_q never exceeds count_q-1; no wrap-around past the last word.
- Words are passed unmodified; no arithmetic on data.

## Timing
- Reset asserted: state IDLE, buffer cleared to 0, count_q=0, sel_q=0; out_valid=0, out_last=0, out_sel=0, out_data=0, busy=0, in_ready=0 while reset is high, 1 from the first cycle after deassertion.
- Reset mid-SEND aborts the load immediately; the unsent words are discarded.
- Latency: load accepted at edge t gives channel 0 on outputs in cycle t+1 (after edge t).
- Without stalls, channel k appears in cycle t+1+k; out_last in cycle t+count.
- Throughput: back-to-back loads give 1 word/cycle with zero bubbles; a count-N load occupies exactly N output cycles.
- count==1: out_valid and out_last both high in the first output cycle.
- A stall of S cycles on word k delays words k..last by exactly S cycles.

## Test plan
- CHANNELS=4, WIDTH=16, load {0x4444,0x3333,0x2222,0x1111} (ch3..ch0), count=4, out_ready=1 -> out_data 0x1111,0x2222,0x3333,0x4444 in cycles t+1..t+4, out_sel 0..3, out_last only in t+4, then out_valid=0.
- Same load, out_ready=0 for 3 cycles while word 1 is presented -> 0x2222/sel=1 held 4 cycles, in_ready=0 throughout, sequence then completes unchanged.
- in_count=2, then in_count=0 -> first load emits ch0, ch1 with out_last on ch1; second load emits all 4 words.
- Two loads with in_valid held high, second data 0xA0..0xA3 -> 8 consecutive out_valid cycles, in_ready=1 only in IDLE and the out_last cycle, second sequence starts immediately after the first out_last.
- Reset asserted asynchronously between clock edges during word 2 -> out_valid, busy, out_sel, out_data go 0 immediately; after deassertion a new load emits from channel 0.
- CHANNELS=8, WIDTH=8, count=8 and count=1 -> correct 8-word sequence with out_sel 0..7; single-word load has out_last in its first output cycle.

Source files
------------

// File: rtl/mux_n_1_serializer.sv
// Time-multiplexing serializer: captures CHANNELS words in one load,
// then emits them one per cycle under valid/ready flow control.
module mux_n_1_serializer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int IDX_W   = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [IDX_W:0]            in_count,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(CHANNELS);

  state_t           state;
  logic [WIDTH-1:0] buffer [CHANNELS];
  logic [IDX_W:0]   count_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W:0]   eff_count;
  logic             last_w;
  logic             load;

  // Zero or oversized counts mean "emit every channel".
  always_comb begin
    eff_count = in_count;
    if (in_count == '0 || in_count > CNT_MAX)
      eff_count = CNT_MAX;
  end

  assign last_w    = (state == SEND) &&
                     ({1'b0, sel_q} == count_q - 1'b1);
  assign in_ready  = !reset &&
                     ((state == IDLE) || (last_w && out_ready));
  assign load      = in_valid && in_ready;

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_last  = last_w;
  assign out_sel   = sel_q;
  assign out_data  = buffer[sel_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count_q <= '0;
      sel_q   <= '0;
      for (int k = 0; k < CHANNELS; k++)
        buffer[k] <= '0;
    end else if (load) begin
      state   <= SEND;
      count_q <= eff_count;
      sel_q   <= '0;
      for (int k = 0; k < CHANNELS; k++)
        buffer[k] <= in_data[k*WIDTH +: WIDTH];
    end else if (state == SEND && out_ready) begin
      if (last_w)
        state <= IDLE;
      else
        sel_q <= sel_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_n_1_serializer.sv
// Directed bench for mux_n_1_serializer: a 4x16 and an 8x8
// instance share clock and reset.
module tb_mux_n_1_serializer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [63:0] a_in_data = '0;
  logic [2:0]  a_in_count = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_valid, a_out_last, a_busy;
  logic        a_out_ready = 1'b1;

  logic [63:0] b_in_data = '0;
  logic [3:0]  b_in_count = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic [2:0]  b_out_sel;
  logic        b_out_valid, b_out_last, b_busy;
  logic        b_out_ready = 1'b1;

  mux_n_1_serializer #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .clock(clock), .reset(reset),
    .in_data(a_in_data), .in_count(a_in_count),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sel(a_out_sel),
    .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(a_out_ready), .busy(a_busy)
  );

  mux_n_1_serializer #(.WIDTH(8), .CHANNELS(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_data(b_in_data), .in_count(b_in_count),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  // {busy, valid, last, in_ready, sel, data}
  wire [21:0] a_obs = {a_busy, a_out_valid, a_out_last,
                       a_in_ready, a_out_sel, a_out_data};
  wire [14:0] b_obs = {b_busy, b_out_valid, b_out_last,
                       b_in_ready, b_out_sel, b_out_data};

  int compared = 0;
  int mismatched = 0;

  logic [15:0] seq [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  localparam logic [63:0] LOAD1 = 64'h4444_3333_2222_1111;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [21:0] ea;
    logic [14:0] eb;
    #2;
    compared++;
    if (a_obs !== 22'h0) begin
      $display("FAIL reset4 got %h exp %h", a_obs, 22'h0);
      mismatched++;
    end
    compared++;
    if (b_obs !== 15'h0) begin
      $display("FAIL reset8 got %h exp %h", b_obs, 15'h0);
      mismatched++;
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    ea = {4'b0001, 2'd0, 16'h0};
    eb = {4'b0001, 3'd0, 8'h0};
    compared++;
    if (a_obs !== ea) begin
      $display("FAIL post_reset4 got %h exp %h", a_obs, ea);
      mismatched++;
    end
    compared++;
    if (b_obs !== eb) begin
      $display("FAIL post_reset8 got %h exp %h", b_obs, eb);
      mismatched++;
    end
  endtask

  task automatic test_basic;
    logic [21:0] e;
    a_in_data = LOAD1;
    a_in_count = 3'd4;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = {1'b1, 1'b1, k == 3, k == 3, 2'(k), seq[k]};
      compared++;
      if (a_obs !== e) begin
        $display("FAIL basic[%0d] got %h exp %h", k, a_obs, e);
        mismatched++;
      end
      tick();
    end
    e = {4'b0001, 2'd3, 16'h4444};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL basic_idle got %h exp %h", a_obs, e);
      mismatched++;
    end
  endtask

  task automatic test_stall;
    logic [21:0] e;
    a_in_data = LOAD1;
    a_in_count = 3'd4;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    e = {4'b1100, 2'd0, 16'h1111};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL stall_w0 got %h exp %h", a_obs, e);
      mismatched++;
    end
    tick();
    a_out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) a_out_ready = 1'b1;
      #1;
      e = {4'b1100, 2'd1, 16'h2222};
      compared++;
      if (a_obs !== e) begin
        $display("FAIL stall_hold[%0d] got %h exp %h", s, a_obs, e);
        mismatched++;
      end
      tick();
    end
    e = {4'b1100, 2'd2, 16'h3333};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL stall_w2 got %h exp %h", a_obs, e);
      mismatched++;
    end
    tick();
    e = {4'b1111, 2'd3, 16'h4444};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL stall_w3 got %h exp %h", a_obs, e);
      mismatched++;
    end
    tick();
    e = {4'b0001, 2'd3, 16'h4444};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL stall_idle got %h exp %h", a_obs, e);
      mismatched++;
    end
  endtask

  task automatic test_count;
    logic [2:0]  cnt [4] = '{3'd2, 3'd0, 3'd5, 3'd1};
    int          nw  [4] = '{2, 4, 4, 1};
    logic [21:0] e;
    for (int c = 0; c < 4; c++) begin
      a_in_data = LOAD1;
      a_in_count = cnt[c];
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      for (int k = 0; k < nw[c]; k++) begin
        e = {1'b1, 1'b1, k == nw[c] - 1, k == nw[c] - 1,
             2'(k), seq[k]};
        compared++;
        if (a_obs !== e) begin
          $display("FAIL count%0d[%0d] got %h exp %h",
                   cnt[c], k, a_obs, e);
          mismatched++;
        end
        tick();
      end
      e = {4'b0001, 2'(nw[c] - 1), seq[nw[c] - 1]};
      compared++;
      if (a_obs !== e) begin
        $display("FAIL count%0d_idle got %h exp %h",
                 cnt[c], a_obs, e);
        mismatched++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] e;
    logic [15:0] d;
    a_in_data = LOAD1;
    a_in_count = 3'd4;
    a_in_valid = 1'b1;
    #1;
    compared++;
    if (a_in_ready !== 1'b1) begin
      $display("FAIL b2b_idle_ready got %b exp 1", a_in_ready);
      mismatched++;
    end
    tick();
    a_in_data = 64'h00A3_00A2_00A1_00A0;
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? seq[i] : 16'h00A0 + 16'(i - 4);
      e = {1'b1, 1'b1, (i % 4) == 3, (i % 4) == 3,
           2'(i % 4), d};
      compared++;
      if (a_obs !== e) begin
        $display("FAIL b2b[%0d] got %h exp %h", i, a_obs, e);
        mismatched++;
      end
      tick();
      if (i == 3) a_in_valid = 1'b0;
    end
    e = {4'b0001, 2'd3, 16'h00A3};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL b2b_idle got %h exp %h", a_obs, e);
      mismatched++;
    end
  endtask

  task automatic test_async_reset;
    logic [21:0] e;
    a_in_data = LOAD1;
    a_in_count = 3'd4;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    e = {4'b1100, 2'd2, 16'h3333};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL arst_pre got %h exp %h", a_obs, e);
      mismatched++;
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (a_obs !== 22'h0) begin
      $display("FAIL arst_now got %h exp %h", a_obs, 22'h0);
      mismatched++;
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    e = {4'b0001, 2'd0, 16'h0};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL arst_after got %h exp %h", a_obs, e);
      mismatched++;
    end
    a_in_data = 64'hDDDD_CCCC_BBBB_AAAA;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    e = {4'b1100, 2'd0, 16'hAAAA};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL arst_reload got %h exp %h", a_obs, e);
      mismatched++;
    end
    repeat (4) tick();
    e = {4'b0001, 2'd3, 16'hDDDD};
    compared++;
    if (a_obs !== e) begin
      $display("FAIL arst_drain got %h exp %h", a_obs, e);
      mismatched++;
    end
  endtask

  task automatic test_wide;
    logic [14:0] e;
    b_in_data = 64'h1716_1514_1312_1110;
    b_in_count = 4'd8;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e = {1'b1, 1'b1, k == 7, k == 7, 3'(k), 8'h10 + 8'(k)};
      compared++;
      if (b_obs !== e) begin
        $display("FAIL wide8[%0d] got %h exp %h", k, b_obs, e);
        mismatched++;
      end
      tick();
    end
    b_in_data = 64'hFFFF_FFFF_FFFF_FF5A;
    b_in_count = 4'd1;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    e = {4'b1111, 3'd0, 8'h5A};
    compared++;
    if (b_obs !== e) begin
      $display("FAIL wide_single got %h exp %h", b_obs, e);
      mismatched++;
    end
    tick();
    e = {4'b0001, 3'd0, 8'h5A};
    compared++;
    if (b_obs !== e) begin
      $display("FAIL wide_idle got %h exp %h", b_obs, e);
      mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_count();
    test_back_to_back();
    test_async_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
